// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM read port, redirect input and decode handshake of the fetch unit.
interface instr_fetch_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    modport master (
        output imem_en, imem_addr, inst_valid, inst, inst_pc, fault,
        input  imem_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_en, imem_addr, inst_valid, inst, inst_pc, fault,
        output imem_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues ROM reads and queues returned words for decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024,
    parameter int          QDEPTH     = 2
) (
    input logic           clk,
    input logic           reset_n,
    instr_fetch_if.master bus
);
    localparam int          PW   = $clog2(QDEPTH);
    localparam int          CW   = PW + 1;
    localparam logic [31:0] LAST = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d, tag_q;
    logic          inflight_q;
    logic [CW-1:0] count_q, count_d, count_left;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [63:0]   mem_q [QDEPTH];
    logic [63:0]   head_q, head_d, push_word;
    logic          issue, push, pop;

    function automatic logic legal(input logic [31:0] a);
        return a[1:0] == 2'b00 && a <= LAST;
    endfunction

    // A redirect kills the in-flight response simply by refusing its push.
    always_comb begin
        issue      = state_q == RUN && legal(pc_q) && !bus.redirect_valid &&
                     32'(count_q) + 32'(inflight_q) < 32'(QDEPTH);
        push       = inflight_q && !bus.redirect_valid;
        pop        = count_q != '0 && bus.inst_ready;
        push_word  = {tag_q, bus.imem_data};
        state_d    = bus.redirect_valid ? (legal(bus.redirect_pc) ? RUN : FAULT) :
                     state_q == IDLE ? (legal(pc_q) ? RUN : FAULT) :
                     (state_q == RUN && !legal(pc_q)) ? FAULT : state_q;
        pc_d       = bus.redirect_valid ? bus.redirect_pc : issue ? pc_q + 32'd4 : pc_q;
        count_left = count_q - CW'(pop);
        rptr_d     = bus.redirect_valid ? wptr_q : rptr_q + PW'(pop);
        wptr_d     = bus.redirect_valid ? wptr_q : wptr_q + PW'(push);
        count_d    = bus.redirect_valid ? '0 : count_left + CW'(push);
        head_d     = count_d == '0 ? head_q : count_left == '0 ? push_word : mem_q[rptr_d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= issue ? pc_q : tag_q;
            inflight_q <= issue;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk)
        if (push) mem_q[wptr_q] <= push_word;

    assign bus.imem_en    = issue;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = count_q != '0;
    assign bus.inst       = head_q[31:0];
    assign bus.inst_pc    = head_q[63:32];
    assign bus.fault      = state_q == FAULT;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random redirects/backpressure against a queue-based fetch model.
module tb_instr_fetch;
    localparam int QDEPTH     = 2;
    localparam int IMEM_BYTES = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] rom [256];
    logic [63:0] q [$];
    logic [63:0] m_last;
    logic [31:0] m_pc, m_fly_pc;
    logic        m_started, m_fault, m_fly;

    instr_fetch_if bus ();
    instr_fetch dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.imem_data <= bus.imem_en ? rom[bus.imem_addr[9:2]] : $urandom;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return a[1:0] == 2'b00 && a <= 32'(IMEM_BYTES - 4);
    endfunction

    function automatic logic exp_en(input logic rv);
        return m_started && !m_fault && legal(m_pc) && !rv && q.size() + int'(m_fly) < QDEPTH;
    endfunction

    function automatic logic [31:0] rand_pc();
        int k = $urandom_range(0, 9);
        if (k == 0) return 32'($urandom_range(0, 1023));
        if (k == 1) return 32'h400 + 32'(4 * $urandom_range(0, 15));
        if (k == 2) return 32'h3F0 + 32'(4 * $urandom_range(0, 3));
        return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic model_reset();
        q.delete();
        m_last    = '0;
        m_pc      = 32'h0;
        m_fly     = 1'b0;
        m_fly_pc  = '0;
        m_started = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic en  = exp_en(rv);
        logic bad = !legal(m_pc);
        if (q.size() != 0) m_last = q[0];
        if (rv) begin
            q.delete();
            m_fly     = 1'b0;
            m_pc      = rpc;
            m_started = 1'b1;
            m_fault   = !legal(rpc);
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (m_fly) q.push_back({m_fly_pc, rom[m_fly_pc[9:2]]});
            if (!m_started) m_fault = bad;
            else if (!m_fault && bad) m_fault = 1'b1;
            m_started = 1'b1;
            m_fly     = en;
            if (en) begin
                m_fly_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all(input logic rv);
        logic [63:0] head = q.size() != 0 ? q[0] : m_last;
        chk("imem_en", bus.imem_en, exp_en(rv));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("inst_valid", bus.inst_valid, q.size() != 0);
        chk("inst", bus.inst, head[31:0]);
        chk("inst_pc", bus.inst_pc, head[63:32]);
        chk("fault", bus.fault, m_fault);
    endtask

    task automatic cycle(input logic rn, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset_n = rn;
        if (!rn) model_reset();
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
        #1 compare_all(rv);
        @(posedge clk);
        if (rn) model_edge(rv, rpc, rdy);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;
        model_reset();
        #1 compare_all(1'b0);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, '0, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, '0, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 32'h3E8, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h402, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h8, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h3F8, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h10, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            logic rv  = $urandom_range(0, 99) < 6;
            logic rdy = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 299) == 0) repeat (2) cycle(1'b0, 1'b0, '0, rdy);
            cycle(1'b1, rv, rand_pc(), rdy);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
